// File: rtl/hs_pkg.sv
// Shared types and protocol constants for the req/ack handshake initiator and responder.
package hs_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitLow,
        StWaitHigh,
        StGap,
        StFin
    } hs_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NO_LOW  = 2'd1,
        ERR_TIMEOUT = 2'd2
    } hs_err_t;

    // Responder timing: ack low this many cycles after req, then high after a further delay.
    localparam int unsigned ACK_LOW_DLY  = 1;
    localparam int unsigned ACK_HIGH_DLY = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hs_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module hs_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/hs_initiator.sv
// Requester side of the single-bit req/ack handshake: issues a burst of num transactions,
// checks each ack low-then-high response and reports count, done and protocol errors.
module hs_initiator
    import hs_pkg::*;
#(
    parameter int unsigned NUM_W   = 8,
    parameter int unsigned TIMEOUT = 4,
    parameter int unsigned GAP     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic             ack,
    output logic             req,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [NUM_W-1:0] txn_cnt
);

    localparam int unsigned      TMR_W    = $clog2(max_u(TIMEOUT, GAP) + 1);
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP > 0) ? GAP - 1 : 0);

    hs_state_t        state_q;
    logic [NUM_W-1:0] num_q;
    logic [NUM_W-1:0] txn_cnt_q;
    logic             req_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    hs_err_t          err_code_q;

    logic [NUM_W-1:0] txn_next;
    logic             last_txn;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_expired;

    assign txn_next = txn_cnt_q + NUM_W'(1);
    assign last_txn = (txn_next == num_q);

    // One timer serves both the ack-high timeout and the inter-request gap.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = TO_LOAD;
        tmr_dec      = 1'b0;
        unique case (state_q)
            StWaitLow: begin
                tmr_load = !ack;
            end
            StWaitHigh: begin
                if (ack) begin
                    tmr_load_val = GAP_LOAD;
                    tmr_load     = !last_txn && (GAP != 0);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StGap: begin
                tmr_dec = 1'b1;
            end
            default: ;
        endcase
    end

    hs_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            num_q      <= '0;
            txn_cnt_q  <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        num_q      <= num;
                        txn_cnt_q  <= '0;
                        err_q      <= 1'b0;
                        err_code_q <= ERR_NONE;
                        if (num != '0) begin
                            state_q <= StReq;
                            req_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    state_q <= StWaitLow;
                end
                StWaitLow: begin
                    if (ack) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_NO_LOW;
                        state_q    <= StFin;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        state_q <= StWaitHigh;
                    end
                end
                StWaitHigh: begin
                    if (ack) begin
                        txn_cnt_q <= txn_next;
                        if (last_txn) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (GAP == 0) begin
                            state_q <= StReq;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= StGap;
                        end
                    end else if (tmr_expired) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= StFin;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                StGap: begin
                    if (tmr_expired) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req      = req_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign txn_cnt  = txn_cnt_q;

    a_req_single: assert property (@(posedge clk) disable iff (!rst_n) req_q |-> ##1 !req_q);

    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> !busy_q);

    a_code_implies_err: assert property (@(posedge clk) disable iff (!rst_n)
        (err_code_q != ERR_NONE) |-> err_q);

    // StIdle is only reachable here when a reset lands inside the window.
    a_check_window: assert property (@(posedge clk) disable iff (!rst_n)
        req_q |-> ##(ACK_LOW_DLY + ACK_HIGH_DLY) (state_q inside {StWaitHigh, StFin, StIdle}));

    c_burst_of_two: cover property (@(posedge clk) disable iff (!rst_n)
        done_q && !err_q && (num_q == NUM_W'(2)));

`ifdef FORMAL
    m_responder: assume property (@(posedge clk) disable iff (!rst_n)
        req |-> ##ACK_LOW_DLY (ack == 1'b0) ##ACK_HIGH_DLY (ack == 1'b1));
`endif

endmodule

// File: tb/tb_hs_initiator.sv
// Randomised and directed bench for hs_initiator against a timeline model of each burst.
module tb_hs_initiator;

    localparam int unsigned NUM_W   = 8;
    localparam int          TIMEOUT = 4;
    localparam int          GAP     = 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [NUM_W-1:0] num   = '0;
    logic             ack   = 1'b0;
    logic             req;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [NUM_W-1:0] txn_cnt;

    hs_initiator #(
        .NUM_W   (NUM_W),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num      (num),
        .ack      (ack),
        .req      (req),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .txn_cnt  (txn_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Responder plan per transaction: -1 no low, >=TIMEOUT never high, else extra low cycles.
    int cur_plan[$];
    int resp_plan[$];
    int ack_hi = -1;

    // Model of the current burst, as absolute cycle numbers.
    bit have_burst = 1'b0;
    int b_s        = 0;
    int b_fin      = 0;
    int idle_from  = 0;
    int b_err      = 0;
    int b_code     = 0;
    int req_cyc[$];
    int txn_vis[$];

    int obs_req, obs_first_req, obs_last_req, obs_busy, obs_done, obs_done_cyc;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic clear_obs();
        obs_req = 0; obs_first_req = -1; obs_last_req = -1;
        obs_busy = 0; obs_done = 0; obs_done_cyc = -1;
    endtask

    task automatic plan_burst(input int s, input int n);
        int t;
        t = s;
        b_s = s; b_err = 0; b_code = 0; b_fin = s;
        req_cyc.delete();
        txn_vis.delete();
        for (int k = 0; k < n; k++) begin
            int d;
            d = (k < cur_plan.size()) ? cur_plan[k] : 0;
            req_cyc.push_back(t);
            if (d < 0) begin
                b_fin = t + 2; b_err = 1; b_code = 1;
                break;
            end
            if (d >= TIMEOUT) begin
                b_fin = t + 2 + TIMEOUT; b_err = 1; b_code = 2;
                break;
            end
            txn_vis.push_back(t + 3 + d);
            if (k == n - 1) b_fin = t + 3 + d;
            else t = t + 3 + d + GAP;
        end
        idle_from  = b_fin + 1;
        have_burst = 1'b1;
        resp_plan  = cur_plan;
    endtask

    task automatic compare_cycle();
        int e_req  = 0;
        int e_busy = 0;
        int e_done = 0;
        int e_txn  = 0;
        int e_err  = 0;
        int e_code = 0;
        if (have_burst && cyc >= b_s) begin
            foreach (req_cyc[i]) if (req_cyc[i] == cyc) e_req = 1;
            foreach (txn_vis[i]) if (txn_vis[i] <= cyc) e_txn++;
            e_busy = int'(cyc < b_fin);
            e_done = int'(cyc == b_fin);
            if (cyc >= b_fin) begin
                e_err  = b_err;
                e_code = b_code;
            end
        end
        chk("req", int'(req), e_req);
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        chk("txn_cnt", int'(txn_cnt), e_txn);
        chk("err", int'(err), e_err);
        chk("err_code", int'(err_code), e_code);
    endtask

    task automatic step(input bit st, input int nm, input bit rs);
        @(posedge clk);
        #1;
        cyc++;
        ack = (cyc == ack_hi);
        if (req) begin
            int d;
            d = (resp_plan.size() > 0) ? resp_plan.pop_front() : 0;
            if (d < 0) ack_hi = cyc + 1;
            else if (d >= TIMEOUT) ack_hi = -1;
            else ack_hi = cyc + 2 + d;
        end
        start = st;
        num   = NUM_W'(nm);
        rst_n = !rs;
        if (rs) begin
            resp_plan.delete();
            ack_hi = -1;
        end
        @(negedge clk);
        compare_cycle();
        if (req) begin
            obs_req++;
            if (obs_first_req < 0) obs_first_req = cyc;
            obs_last_req = cyc;
        end
        if (busy) obs_busy++;
        if (done) begin
            obs_done++;
            obs_done_cyc = cyc;
        end
        if (rs) begin
            have_burst = 1'b0;
            idle_from  = cyc + 1;
        end else if (st && cyc >= idle_from) begin
            plan_burst(cyc + 1, nm);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    task automatic settle(input int max_cyc);
        for (int i = 0; i < max_cyc && cyc <= idle_from + 1; i++) step(1'b0, 0, 1'b0);
    endtask

    task automatic plan_fill(input int n, input int d);
        cur_plan.delete();
        for (int i = 0; i < n; i++) cur_plan.push_back(d);
    endtask

    initial begin
        clear_obs();
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        chk("rst_req", int'(req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_txn", int'(txn_cnt), 0);
        chk("rst_err_code", int'(err_code), 0);
        idle(2);

        // Nominal burst of three.
        plan_fill(3, 0);
        clear_obs();
        step(1'b1, 3, 1'b0);
        settle(40);
        chk("nom_reqs", obs_req, 3);
        chk("nom_req_span", obs_last_req - obs_first_req, 8);
        chk("nom_latency", obs_done_cyc - obs_first_req, 11);
        chk("nom_busy", obs_busy, 11);
        chk("nom_done", obs_done, 1);
        chk("nom_txn", int'(txn_cnt), 3);
        chk("nom_err", int'(err), 0);

        // Ack already high in the low-check cycle.
        plan_fill(1, -1);
        clear_obs();
        step(1'b1, 2, 1'b0);
        settle(40);
        chk("nolow_err", int'(err), 1);
        chk("nolow_code", int'(err_code), 1);
        chk("nolow_txn", int'(txn_cnt), 0);
        chk("nolow_latency", obs_done_cyc - obs_first_req, 2);
        chk("nolow_reqs", obs_req, 1);

        // Ack never rises.
        plan_fill(1, TIMEOUT);
        clear_obs();
        step(1'b1, 1, 1'b0);
        settle(40);
        chk("to_code", int'(err_code), 2);
        chk("to_latency", obs_done_cyc - obs_first_req, 6);
        chk("to_txn", int'(txn_cnt), 0);
        chk("to_done", obs_done, 1);

        // Starts while busy and in the FIN cycle are ignored.
        plan_fill(4, 0);
        clear_obs();
        step(1'b1, 4, 1'b0);
        for (int i = 0; i < 40 && cyc + 1 <= b_fin; i++)
            step((i % 3 == 0) || (cyc + 1 == b_fin), 7, 1'b0);
        settle(40);
        chk("ign_txn", int'(txn_cnt), 4);
        chk("ign_reqs", obs_req, 4);
        chk("ign_done", obs_done, 1);
        chk("ign_busy", obs_busy, 15);

        // Reset during WAIT_HIGH of the second transaction.
        plan_fill(1, 0);
        cur_plan.push_back(2);
        clear_obs();
        step(1'b1, 3, 1'b0);
        for (int i = 0; i < 20 && cyc + 1 < b_s + 6; i++) step(1'b0, 0, 1'b0);
        chk("mid_pre_txn", int'(txn_cnt), 1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("mid_req", int'(req), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_txn", int'(txn_cnt), 0);
        idle(8);
        chk("mid_no_done", obs_done, 0);
        chk("mid_reqs", obs_req, 2);

        // Empty burst.
        clear_obs();
        step(1'b1, 0, 1'b0);
        idle(5);
        chk("zero_done", obs_done, 1);
        chk("zero_busy", obs_busy, 0);
        chk("zero_reqs", obs_req, 0);

        // Largest legal burst.
        cur_plan.delete();
        clear_obs();
        step(1'b1, 255, 1'b0);
        settle(1200);
        chk("max_txn", int'(txn_cnt), 255);
        chk("max_reqs", obs_req, 255);
        chk("max_done", obs_done, 1);
        chk("max_latency", obs_done_cyc - obs_first_req, 1019);
        chk("max_err", int'(err), 0);

        // Random starts, responder behaviour and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            cur_plan.delete();
            for (int k = 0; k < 5; k++) begin
                int r;
                r = int'($urandom_range(0, 15));
                if (r == 0) cur_plan.push_back(-1);
                else if (r == 1) cur_plan.push_back(TIMEOUT + int'($urandom_range(0, 1)));
                else cur_plan.push_back(int'($urandom_range(0, 3)));
            end
            step($urandom_range(0, 7) == 0, int'($urandom_range(0, 5)),
                 $urandom_range(0, 399) == 0);
        end
        settle(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1);
    end

endmodule
